// File: rtl/fir_pkg.sv
// Shared widths and reset coefficients for the 4-tap transposed FIR.
package fir_pkg;

  function automatic int acc_width(int dw, int cw);
    return dw + cw + 2;
  endfunction

  function automatic int out_width(int dw, int cw, int fw);
    return dw + cw - fw + 2;
  endfunction

  function automatic logic signed [15:0] default_coef(logic [1:0] idx);
    logic signed [15:0] c;
    c = 16'sh1000;
    unique case (idx)
      2'd0: c = 16'sh1000;
      2'd1: c = 16'sh2000;
      2'd2: c = 16'sh2000;
      2'd3: c = 16'sh1000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Four-entry coefficient register file: one write port, all taps read in parallel.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEFF_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_we,
  input  logic [1:0]                  i_addr,
  input  logic [COEFF_WIDTH-1:0]      i_wdata,
  output logic [3:0][COEFF_WIDTH-1:0] o_coef
);

  logic [3:0][COEFF_WIDTH-1:0] coef_q;
  logic [3:0][COEFF_WIDTH-1:0] coef_d;

  always_comb begin
    coef_d = coef_q;
    if (i_we) coef_d[i_addr] = i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        coef_q[i] <= COEFF_WIDTH'(default_coef(2'(i)));
    end else begin
      coef_q <= coef_d;
    end
  end

  assign o_coef = coef_q;

endmodule

// File: rtl/fir_4_tap_transposed_stream.sv
// Transposed-form 4-tap FIR with valid/ready streaming and a 1-entry output register.
module fir_4_tap_transposed_stream
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH           = 16,
  parameter int COEFF_WIDTH          = 16,
  parameter int COEFF_FRACTION_WIDTH = 15,
  localparam int OUT_WIDTH =
    out_width(DATA_WIDTH, COEFF_WIDTH, COEFF_FRACTION_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic signed [OUT_WIDTH-1:0]   o_data_sum,
  output logic                          o_data_valid,
  input  logic                          i_ready,
  input  logic                          i_coef_we,
  input  logic [1:0]                    i_coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] i_coef_data,
  output logic                          o_primed
);

  localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int FW    = COEFF_FRACTION_WIDTH;

  logic [3:0][COEFF_WIDTH-1:0] coef;
  logic signed [ACC_W-1:0]     x_ext;
  logic signed [ACC_W-1:0]     p [4];
  logic signed [ACC_W-1:0]     y_full;
  logic signed [ACC_W-1:0]     s1_q, s2_q, s3_q;
  logic signed [ACC_W-1:0]     s1_d, s2_d, s3_d;
  logic signed [OUT_WIDTH-1:0] y_q, y_d;
  logic                        v_q, v_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic                        accept;

  fir_coef_bank #(
    .COEFF_WIDTH(COEFF_WIDTH)
  ) u_coef (
    .clk    (clk),
    .reset  (reset),
    .i_we   (i_coef_we),
    .i_addr (i_coef_addr),
    .i_wdata(i_coef_data),
    .o_coef (coef)
  );

  assign x_ext  = ACC_W'(i_data);
  assign o_ready = !reset || !v_q || i_ready;
  assign accept = reset && i_valid && o_ready;

  always_comb begin
    for (int k = 0; k < 4; k++)
      p[k] = x_ext * ACC_W'($signed(coef[k]));
  end

  assign y_full = p[0] + s1_q;

  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    s3_d  = s3_q;
    y_d   = y_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (v_q && i_ready) v_d = 1'b0;
    if (accept) begin
      s1_d = p[1] + s2_q;
      s2_d = p[2] + s3_q;
      s3_d = p[3];
      // Floor shift by FW then truncate: the slice does both at once.
      y_d  = y_full[FW +: OUT_WIDTH];
      v_d  = 1'b1;
      if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      y_q   <= '0;
      v_q   <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      y_q   <= y_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_data_sum   = y_q;
  assign o_data_valid = v_q;
  assign o_primed     = (cnt_q == 2'd3);

endmodule

// File: tb/tb_fir_4_tap_transposed_stream.sv
// Directed bench for the 4-tap transposed FIR stream.
module tb_fir_4_tap_transposed_stream;

  logic               clk;
  logic               reset;
  logic signed [15:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic signed [18:0] o_data_sum;
  logic               o_data_valid;
  logic               i_ready;
  logic               i_coef_we;
  logic [1:0]         i_coef_addr;
  logic signed [15:0] i_coef_data;
  logic               o_primed;

  int total = 0;
  int bad   = 0;

  fir_4_tap_transposed_stream dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data_sum  (o_data_sum),
    .o_data_valid(o_data_valid),
    .i_ready     (i_ready),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .o_primed    (o_primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [15:0] x);
    i_valid = 1'b1;
    i_data  = x;
    tick();
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  int imp_exp [5] = '{2048, 4096, 4096, 2048, 0};
  int pos_exp [5] = '{4095, 12287, 20479, 24575, 24575};
  int neg_exp [5] = '{-4096, -12288, -20480, -24576, -24576};

  initial begin
    reset       = 1'b0;
    i_data      = '0;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    i_coef_we   = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    tick();
    i_valid = 1'b1;
    i_data  = 16'sh4000;
    tick();
    chk("rst_valid", o_data_valid, 0);
    chk("rst_sum", o_data_sum, 0);
    chk("rst_primed", o_primed, 0);
    chk("rst_ready", o_ready, 1);
    i_valid = 1'b0;
    reset   = 1'b1;

    // impulse and primed
    for (int i = 0; i < 5; i++) begin
      push(i == 0 ? 16'sh4000 : 16'sh0000);
      chk($sformatf("imp_v%0d", i), o_data_valid, 1);
      chk($sformatf("imp_y%0d", i), o_data_sum, imp_exp[i]);
      chk($sformatf("primed%0d", i), o_primed, i >= 2);
    end
    tick();
    chk("imp_drain", o_data_valid, 0);
    chk("primed_hold", o_primed, 1);

    // positive step
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(16'sh7FFF);
      chk($sformatf("stp_p%0d", i), o_data_sum, pos_exp[i]);
    end

    // negative step
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(16'sh8000);
      chk($sformatf("stp_n%0d", i), o_data_sum, neg_exp[i]);
    end

    // backpressure
    do_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 16'sh4000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_ready%0d", i), o_ready, 0);
      chk($sformatf("bp_valid%0d", i), o_data_valid, 1);
      chk($sformatf("bp_sum%0d", i), o_data_sum, 2048);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    chk("bp_consumed", o_data_valid, 0);
    push(16'sh0000);
    chk("bp_one_accept", o_data_sum, 4096);

    // coefficient write with same-cycle accept
    do_reset();
    i_coef_we   = 1'b1;
    i_coef_addr = 2'd0;
    i_coef_data = 16'sh4000;
    push(16'sh4000);
    i_coef_we = 1'b0;
    chk("cw_old_h0", o_data_sum, 2048);
    push(16'sh0000);
    chk("cw_no_flush", o_data_sum, 4096);
    push(16'sh0000);
    push(16'sh0000);
    chk("cw_tail", o_data_sum, 2048);
    push(16'sh4000);
    chk("cw_new_h0", o_data_sum, 8192);

    // reset mid-stream
    push(16'sh0000);
    push(16'sh0000);
    push(16'sh0000);
    push(16'sh4000);
    push(16'sh0000);
    chk("mid_pre", o_data_sum, 4096);
    reset = 1'b0;
    tick();
    chk("mid_valid", o_data_valid, 0);
    chk("mid_primed", o_primed, 0);
    chk("mid_ready", o_ready, 1);
    reset = 1'b1;
    push(16'sh4000);
    chk("mid_first", o_data_sum, 2048);
    chk("mid_primed1", o_primed, 0);
    push(16'sh0000);
    chk("mid_second", o_data_sum, 4096);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
